// File: rtl/dmux_arb_pkg.sv
// Shared definitions for the 8-lane round-robin demux arbiter.
//   N_LANES          : number of requesters / demux output lanes
//   SEL_W            : width of a lane index
//   HOLD_MAX_DEFAULT : default grant hold limit (DMUX8_ARB_TIMEOUT_EN builds)
//   arb_state_t      : arbiter FSM states
//   lane_onehot()    : lane index -> one-hot lane vector
package dmux_arb_pkg;

  localparam int unsigned N_LANES          = 8;
  localparam int unsigned SEL_W            = 3;
  localparam int unsigned HOLD_MAX_DEFAULT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  function automatic logic [N_LANES-1:0] lane_onehot(input logic [SEL_W-1:0] idx);
    lane_onehot      = '0;
    lane_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker for 8 requesters.
// Scans req starting at lane ptr, upward with mod-8 wrap, and returns the
// first requesting lane.
//   req   [7:0] in  : request vector, bit i = lane i
//   ptr   [2:0] in  : highest-priority lane for this pick
//   valid       out : any request present
//   idx   [2:0] out : winning lane
module rr_pick8
  import dmux_arb_pkg::*;
(
  input  logic [N_LANES-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               valid,
  output logic [SEL_W-1:0]   idx
);

  logic [2*N_LANES-1:0] dbl;
  logic [N_LANES-1:0]   rot;
  logic [SEL_W-1:0]     off;
  logic                 found;

  // Rotate so that lane ptr lands at bit 0, priority-encode the lowest set
  // bit, then add ptr back (3-bit add wraps naturally).
  always_comb begin
    dbl   = {req, req};
    rot   = dbl[{1'b0, ptr} +: N_LANES];
    off   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      if (rot[i] && !found) begin
        found = 1'b1;
        off   = SEL_W'(i);
      end
    end
    valid = |req;
    idx   = ptr + off;
  end

endmodule

// File: rtl/dmux8_rr_arbiter.sv
// Round-robin arbiter that owns the select of an 8-way demux.
// A registered winner steers the shared bit 'in' to out[sel] while busy.
// Optional feature: define DMUX8_ARB_TIMEOUT_EN to force release of a grant
// held HOLD_MAX BUSY cycles without done (timeout pulses for one cycle).
//   clk          in  : clock, rising edge
//   rst_n        in  : asynchronous active-low reset
//   req    [7:0] in  : per-lane requests
//   done         in  : owner releases (only looked at in BUSY)
//   in           in  : shared data bit
//   grant  [7:0] out : registered one-hot grant, zero when idle
//   sel    [2:0] out : registered index of current/last winner
//   busy         out : high while a grant is held
//   out    [7:0] out : demuxed data, out[i] = in & busy & (sel == i)
//   timeout      out : one-cycle pulse after a forced release
module dmux8_rr_arbiter
  import dmux_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = HOLD_MAX_DEFAULT,
  parameter int unsigned CNT_W    = 8
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_LANES-1:0] req,
  input  logic               done,
  input  logic               in,
  output logic [N_LANES-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic [N_LANES-1:0] out,
  output logic               timeout
);

  arb_state_t       state;
  logic [SEL_W-1:0] ptr;
  logic             pick_valid;
  logic [SEL_W-1:0] pick_idx;
  logic             release_req;
  logic             hold_exp;

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign release_req = done | ~req[sel];

`ifdef DMUX8_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
  logic             timeout_q;
  assign hold_exp = (cnt == CNT_W'(HOLD_MAX - 1));
  assign timeout  = timeout_q;
`else
  logic unused_cfg;
  assign unused_cfg = (CNT_W > 0) && (HOLD_MAX > 0);
  assign hold_exp   = 1'b0;
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      sel   <= '0;
      busy  <= 1'b0;
      ptr   <= '0;
`ifdef DMUX8_ARB_TIMEOUT_EN
      cnt       <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef DMUX8_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_valid) begin
            sel   <= pick_idx;
            grant <= lane_onehot(pick_idx);
            busy  <= 1'b1;
            state <= BUSY;
`ifdef DMUX8_ARB_TIMEOUT_EN
            cnt   <= '0;
`endif
          end
        end
        BUSY: begin
          if (release_req || hold_exp) begin
            grant <= '0;
            busy  <= 1'b0;
            ptr   <= sel + 3'd1;
            state <= IDLE;
`ifdef DMUX8_ARB_TIMEOUT_EN
            // A real release on the limit edge is not reported as a timeout.
            timeout_q <= ~release_req;
`endif
          end else begin
`ifdef DMUX8_ARB_TIMEOUT_EN
            cnt <= cnt + 1'b1;
`endif
          end
        end
      endcase
    end
  end

  always_comb begin
    out = '0;
    if (busy) out = lane_onehot(sel) & {N_LANES{in}};
  end

endmodule

// File: tb/tb_dmux8_rr_arbiter.sv
// Directed self-checking bench for dmux8_rr_arbiter.
module tb_dmux8_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic       in;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       busy;
  logic [7:0] out;
  logic       timeout;

  int unsigned errors = 0;
  int unsigned checks = 0;

  dmux8_rr_arbiter #(
    .HOLD_MAX (4),
    .CNT_W    (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .in      (in),
    .grant   (grant),
    .sel     (sel),
    .busy    (busy),
    .out     (out),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [7:0] g, input logic [2:0] s,
                        input logic b, input logic [7:0] o);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".sel"},   32'(sel),   32'(s));
    chk({tag, ".busy"},  32'(busy),  32'(b));
    chk({tag, ".out"},   32'(out),   32'(o));
    chk({tag, ".onehot"}, 32'($onehot0(grant)), 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_g;
    rst_n = 1'b0; req = '0; done = 1'b0; in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_st("rst", 8'h00, 3'd0, 1'b0, 8'h00);
    chk("rst.timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;

    // No requests: stays idle.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_st("idle", 8'h00, 3'd0, 1'b0, 8'h00);
    end

    // req=24 from ptr 0 picks lane 2, then lane 5 after release.
    req = 8'h24; in = 1'b1;
    tick();
    chk_st("g2", 8'h04, 3'd2, 1'b1, 8'h04);
    in = 1'b0; #1;
    chk("g2.in0.out", 32'(out), 32'h00);
    in = 1'b1; done = 1'b1;
    tick();
    chk_st("g2.rel", 8'h00, 3'd2, 1'b0, 8'h00);
    done = 1'b0;
    tick();
    chk_st("g5", 8'h20, 3'd5, 1'b1, 8'h20);
    done = 1'b1;
    tick();
    chk_st("g5.rel", 8'h00, 3'd5, 1'b0, 8'h00);
    done = 1'b0; req = 8'h00;
    tick();
    chk_st("g5.idle", 8'h00, 3'd5, 1'b0, 8'h00);

    // Full rotation with all lanes requesting; done every third cycle.
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      exp_g = 8'h01 << (k % 8);
      tick();
      chk_st("rr.own", exp_g, 3'(k % 8), 1'b1, exp_g);
      tick();
      chk_st("rr.hold", exp_g, 3'(k % 8), 1'b1, exp_g);
      done = 1'b1;
      tick();
      chk_st("rr.dead", 8'h00, 3'(k % 8), 1'b0, 8'h00);
      done = 1'b0;
    end
    req = 8'h00;

    // Lane 6 withdraws; pointer wraps 7 -> 0.
    do_reset();
    req = 8'h40;
    tick();
    chk_st("w6", 8'h40, 3'd6, 1'b1, 8'h40);
    req = 8'h41;
    tick();
    chk_st("w6.ign", 8'h40, 3'd6, 1'b1, 8'h40);
    req = 8'h01;
    tick();
    chk_st("w6.rel", 8'h00, 3'd6, 1'b0, 8'h00);
    tick();
    chk_st("w0", 8'h01, 3'd0, 1'b1, 8'h01);
    req = 8'h00; done = 1'b1;
    tick();
    done = 1'b0;

    // Done in IDLE is ignored.
    done = 1'b1;
    tick();
    chk_st("idle.done", 8'h00, 3'd0, 1'b0, 8'h00);
    done = 1'b0;

    // Asynchronous reset while lane 3 owns the line.
    do_reset();
    req = 8'h08;
    tick();
    chk_st("r3", 8'h08, 3'd3, 1'b1, 8'h08);
    rst_n = 1'b0;
    #1;
    chk_st("r3.async", 8'h00, 3'd0, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_st("r3.regrant", 8'h08, 3'd3, 1'b1, 8'h08);
    req = 8'h00;
    tick();

    // Hold limit behaviour with req=03 and done low.
    do_reset();
    req = 8'h03;
`ifdef DMUX8_ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_st("to.hold0", 8'h01, 3'd0, 1'b1, 8'h01);
      chk("to.hold0.to", 32'(timeout), 32'd0);
    end
    tick();
    chk_st("to.rel0", 8'h00, 3'd0, 1'b0, 8'h00);
    chk("to.pulse", 32'(timeout), 32'd1);
    tick();
    chk_st("to.g1", 8'h02, 3'd1, 1'b1, 8'h02);
    chk("to.pulse.end", 32'(timeout), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_st("to.hold1", 8'h02, 3'd1, 1'b1, 8'h02);
    end
    done = 1'b1;
    tick();
    chk_st("to.done.rel", 8'h00, 3'd1, 1'b0, 8'h00);
    chk("to.done.noto", 32'(timeout), 32'd0);
    done = 1'b0;
`else
    tick();
    chk_st("nto.g0", 8'h01, 3'd0, 1'b1, 8'h01);
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("nto.hold", 32'(grant), 32'h01);
      chk("nto.to", 32'(timeout), 32'd0);
    end
    done = 1'b1;
    tick();
    chk_st("nto.rel", 8'h00, 3'd0, 1'b0, 8'h00);
    done = 1'b0;
    tick();
    chk_st("nto.g1", 8'h02, 3'd1, 1'b1, 8'h02);
`endif
    req = 8'h00;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
